// File: rtl/results_buffer_ctrl.sv
// Single-port results SRAM controller: accumulator writes vs. autonomous drain bursts.
// Define RESULTS_RR_ARB_EN for round-robin arbitration; default is fixed write priority.
module results_buffer_ctrl #(
    parameter int ADDRESSSIZE = 10,
    parameter int WORDSIZE    = 160
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ADDRESSSIZE-1:0] wr_addr,
    input  logic [WORDSIZE-1:0]    wr_data,
    input  logic                   drain_start,
    input  logic [ADDRESSSIZE-1:0] drain_base,
    input  logic [ADDRESSSIZE:0]   drain_count,
    output logic                   drain_busy,
    output logic                   drain_done,
    output logic                   rd_valid,
    output logic [ADDRESSSIZE-1:0] rd_addr,
    output logic [WORDSIZE-1:0]    rd_data,
    output logic                   sram_write_enable,
    output logic [ADDRESSSIZE-1:0] sram_address,
    output logic [WORDSIZE-1:0]    sram_data_in,
    input  logic [WORDSIZE-1:0]    sram_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDRESSSIZE-1:0] cur_addr_q, cur_addr_d;
    logic [ADDRESSSIZE:0]   remaining_q, remaining_d;
    logic                   issued_q, issued_d;
    logic [ADDRESSSIZE-1:0] rd_addr_q, rd_addr_d;
    logic                   done_q, done_d;
    logic                   read_req;
    logic                   grant_rd;
    logic                   grant_wr;

`ifdef RESULTS_RR_ARB_EN
    logic rr_last_q, rr_last_d;
    logic contend;

    always_comb begin
        read_req  = (state_q == DRAIN);
        contend   = read_req && wr_valid;
        grant_rd  = read_req && (!wr_valid || !rr_last_q);
        grant_wr  = wr_valid && !grant_rd;
        rr_last_d = rr_last_q;
        if (contend) begin
            rr_last_d = grant_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= 1'b0;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`else
    always_comb begin
        read_req = (state_q == DRAIN);
        grant_rd = read_req && !wr_valid;
        grant_wr = wr_valid;
    end
`endif

    // SRAM port: a granted read steals the address, otherwise the write side owns it
    always_comb begin
        wr_ready          = !grant_rd;
        sram_write_enable = grant_wr;
        sram_address      = '0;
        if (grant_rd) begin
            sram_address = cur_addr_q;
        end else if (wr_valid) begin
            sram_address = wr_addr;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        rd_addr_d   = rd_addr_q;
        issued_d    = 1'b0;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (drain_start) begin
                    cur_addr_d  = drain_base;
                    remaining_d = drain_count;
                    if (drain_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (grant_rd) begin
                    cur_addr_d  = cur_addr_q + ADDRESSSIZE'(1);
                    remaining_d = remaining_q - (ADDRESSSIZE+1)'(1);
                    rd_addr_d   = cur_addr_q;
                    issued_d    = 1'b1;
                    if (remaining_q == (ADDRESSSIZE+1)'(1)) begin
                        state_d = FLUSH;
                        done_d  = 1'b1;
                    end
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            issued_q    <= 1'b0;
            rd_addr_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            issued_q    <= issued_d;
            rd_addr_q   <= rd_addr_d;
            done_q      <= done_d;
        end
    end

    assign drain_busy   = (state_q != IDLE);
    assign drain_done   = done_q;
    assign rd_valid     = issued_q;
    assign rd_addr      = rd_addr_q;
    assign rd_data      = sram_data_out;
    assign sram_data_in = wr_data;

endmodule

// File: tb/tb_results_buffer_ctrl.sv
// Bench for results_buffer_ctrl: SRAM model, read scoreboard, table vectors, drain sequences.
module tb_results_buffer_ctrl;

    localparam int AW = 10;
    localparam int WS = 160;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [WS-1:0] wr_data;
    logic          drain_start;
    logic [AW-1:0] drain_base;
    logic [AW:0]   drain_count;
    logic          drain_busy;
    logic          drain_done;
    logic          rd_valid;
    logic [AW-1:0] rd_addr;
    logic [WS-1:0] rd_data;
    logic          sram_write_enable;
    logic [AW-1:0] sram_address;
    logic [WS-1:0] sram_data_in;
    logic [WS-1:0] sram_data_out;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [WS-1:0] data;
    } rd_exp_t;

    typedef struct {
        logic          wv;
        logic [AW-1:0] wa;
        logic [WS-1:0] wd;
        logic          e_ready;
        logic          e_we;
        logic [AW-1:0] e_addr;
    } vec_t;

    rd_exp_t       sb[$];
    logic [WS-1:0] mem [DEPTH];
    logic [WS-1:0] shadow [DEPTH];
    vec_t          vecs [4];

    always #5 clk = ~clk;

    results_buffer_ctrl #(.ADDRESSSIZE(AW), .WORDSIZE(WS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .drain_start(drain_start),
        .drain_base(drain_base),
        .drain_count(drain_count),
        .drain_busy(drain_busy),
        .drain_done(drain_done),
        .rd_valid(rd_valid),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .sram_write_enable(sram_write_enable),
        .sram_address(sram_address),
        .sram_data_in(sram_data_in),
        .sram_data_out(sram_data_out)
    );

    // SRAM model: registered read, output held on write cycles
    always @(posedge clk) begin
        if (sram_write_enable) begin
            mem[sram_address] <= sram_data_in;
        end else begin
            sram_data_out <= mem[sram_address];
        end
    end

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_rd_valid", 256'(1), 256'(0));
            end else begin
                rd_exp_t e;
                e = sb.pop_front();
                check("rd_addr", 256'(rd_addr), 256'(e.addr));
                check("rd_data", 256'(rd_data), 256'(e.data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [WS-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        shadow[a] = d;
    endtask

    task automatic start_drain(input logic [AW-1:0] base, input int cnt, input int npush);
        for (int i = 0; i < npush; i++) begin
            rd_exp_t e;
            logic [AW-1:0] a;
            a = base + AW'(i);
            e.addr = a;
            e.data = shadow[a];
            sb.push_back(e);
        end
        drain_base  = base;
        drain_count = (AW+1)'(cnt);
        drain_start = 1'b1;
        @(posedge clk);
        #1;
        drain_start = 1'b0;
    endtask

    // cycle 0 is the first cycle a read can issue
    task automatic check_run(input int n, input string nm);
        logic [2:0] e;
        for (int k = 0; k <= n + 1; k++) begin
            @(negedge clk);
            e[2] = (n > 0) && (k <= n);
            e[1] = (k == n);
            e[0] = (k >= 1) && (k <= n);
            check(nm, 256'({drain_busy, drain_done, rd_valid}), 256'(e));
        end
    endtask

    task automatic check_reset_outs(input string nm);
        logic [24:0] exp_v;
        exp_v = {1'b1, 24'b0};
        check(nm, 256'({wr_ready, drain_busy, drain_done, rd_valid, rd_addr,
                        sram_write_enable, sram_address}), 256'(exp_v));
    endtask

    initial begin
        vecs[0] = '{wv: 1'b0, wa: 10'd0,    wd: 160'd0,   e_ready: 1'b1, e_we: 1'b0, e_addr: 10'd0};
        vecs[1] = '{wv: 1'b1, wa: 10'd5,    wd: 160'd123, e_ready: 1'b1, e_we: 1'b1, e_addr: 10'd5};
        vecs[2] = '{wv: 1'b1, wa: 10'd1023, wd: {32'hdead, 128'h1}, e_ready: 1'b1, e_we: 1'b1, e_addr: 10'd1023};
        vecs[3] = '{wv: 1'b1, wa: 10'd512,  wd: 160'h5a5a, e_ready: 1'b1, e_we: 1'b1, e_addr: 10'd512};

        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = WS'(i * 3 + 7);
            shadow[i] = WS'(i * 3 + 7);
        end

        rst_n       = 1'b0;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        drain_start = 1'b0;
        drain_base  = '0;
        drain_count = '0;
        #2;
        check_reset_outs("reset_values");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            wr_valid = vecs[i].wv;
            wr_addr  = vecs[i].wa;
            wr_data  = vecs[i].wd;
            #1;
            check("idle_vec_ctrl", 256'({wr_ready, sram_write_enable, sram_address}),
                  256'({vecs[i].e_ready, vecs[i].e_we, vecs[i].e_addr}));
            check("idle_vec_data", 256'(sram_data_in), 256'(vecs[i].wd));
        end
        wr_valid = 1'b0;
        wr_addr  = '0;

        for (int i = 0; i < 8; i++) begin
            do_write(AW'(i), WS'(100 + i));
        end
        start_drain(10'd0, 8, 8);
        check_run(8, "drain8");

        start_drain(10'd1022, 4, 4);
        check_run(4, "drain_wrap");
        start_drain(10'd200, 0, 0);
        check_run(0, "drain_zero");

        // reset after three reads issued: only two results ever surface
        start_drain(10'd0, 8, 2);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check_reset_outs("reset_mid_drain");
        repeat (2) begin
            @(negedge clk);
            check("reset_hold", 256'({drain_done, rd_valid, drain_busy}), 256'(0));
        end
        rst_n = 1'b1;
        check("sb_after_reset", 256'(sb.size()), 256'(0));
        start_drain(10'd100, 3, 3);
        check_run(3, "drain_after_reset");

`ifdef RESULTS_RR_ARB_EN
        start_drain(10'd5, 1, 1);
        wr_valid = 1'b1;
        wr_addr  = 10'd5;
        wr_data  = 160'hAA;
        @(negedge clk);
        check("same_addr_k0", 256'({wr_ready, sram_write_enable, rd_valid}), 256'(3'b000));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("same_addr_k1", 256'({wr_ready, sram_write_enable, rd_valid, drain_done}),
              256'(4'b1111));
        @(posedge clk);
        #1;
        wr_valid  = 1'b0;
        shadow[5] = 160'hAA;
        @(negedge clk);
        check("same_addr_idle", 256'(drain_busy), 256'(0));
`else
        shadow[5] = 160'hAA;
        start_drain(10'd5, 1, 1);
        wr_valid = 1'b1;
        wr_addr  = 10'd5;
        wr_data  = 160'hAA;
        @(negedge clk);
        check("same_addr_k0", 256'({wr_ready, sram_write_enable, rd_valid}), 256'(3'b110));
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        check_run(1, "same_addr_read");
`endif
        start_drain(10'd5, 1, 1);
        check_run(1, "same_addr_verify");

`ifdef RESULTS_RR_ARB_EN
        start_drain(10'd0, 4, 4);
        wr_valid = 1'b1;
        wr_addr  = 10'd50;
        wr_data  = 160'd777;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] e;
            @(negedge clk);
            e = {k[0], k[0], k == 7, 1'b1};
            check("rr_contend", 256'({wr_ready, rd_valid, drain_done, drain_busy}), 256'(e));
            @(posedge clk);
            #1;
        end
        wr_valid   = 1'b0;
        shadow[50] = 160'd777;
        @(negedge clk);
        check("rr_contend_end", 256'(drain_busy), 256'(0));
`else
        start_drain(10'd0, 4, 4);
        wr_valid = 1'b1;
        wr_addr  = 10'd50;
        wr_data  = 160'd777;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("stall", 256'({wr_ready, sram_write_enable, rd_valid, drain_busy}),
                  256'(4'b1101));
            @(posedge clk);
            #1;
        end
        wr_valid   = 1'b0;
        shadow[50] = 160'd777;
        check_run(4, "stall_resume");
`endif

        start_drain(10'd0, 8, 8);
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                drain_base  = 10'd300;
                drain_count = 11'd3;
                drain_start = 1'b1;
                @(posedge clk);
                #1;
                drain_start = 1'b0;
            end
        join_none
        check_run(8, "ignored_start");

        start_drain(10'd512, DEPTH, DEPTH);
        check_run(DEPTH, "drain_full");

        check("sb_empty", 256'(sb.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
